// File: rtl/pipe_sched_arb.sv
// pipe_sched_arb: round-robin scheduler feeding a 3-stage pipe that computes
// F = ((A+B) + (C-D)) * D, all unsigned and mod 2**N. A valid bit and the
// requester ID travel with each operation. Results leave over a valid/ready
// port; a held result (res_valid & ~res_ready) freezes the whole pipe.
// Optional feature macro: PIPE_SCHED_STAT_EN adds saturating stall_cnt and
// issue_cnt outputs.
module pipe_sched_arb #(
  parameter int N    = 10,
  parameter int ID_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(1<<ID_W)-1:0]        req,
  input  logic [(1<<ID_W)*N-1:0]      op_a,
  input  logic [(1<<ID_W)*N-1:0]      op_b,
  input  logic [(1<<ID_W)*N-1:0]      op_c,
  input  logic [(1<<ID_W)*N-1:0]      op_d,
  output logic [(1<<ID_W)-1:0]        gnt,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [N-1:0]                res_data,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
`ifdef PIPE_SCHED_STAT_EN
  ,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 issue_cnt
`endif
);

  localparam int NREQ = 1 << ID_W;

  logic            stall;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]    a_p0, b_p0, c_p0, d_p0;
  logic [N-1:0]    x1_p1_d, x2_p1_d;

  logic            vld_p1_q;
  logic [N-1:0]    x1_p1_q, x2_p1_q, d_p1_q;
  logic [ID_W-1:0] id_p1_q;

  logic            vld_p2_q;
  logic [N-1:0]    x3_p2_d;
  logic [N-1:0]    x3_p2_q, d_p2_q;
  logic [ID_W-1:0] id_p2_q;

  logic [N-1:0]    prod_p2;
  logic            res_valid_q;
  logic [N-1:0]    res_data_q;
  logic [ID_W-1:0] res_id_q;

  // A result waiting on a not-ready consumer holds every stage in place.
  assign stall = res_valid_q & ~res_ready;

  // Round-robin search from the pointer; no grant while stalled or in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
    if (rst_n && !stall) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = ptr_q + ID_W'(i);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      gnt[gnt_idx] = gnt_any;
    end
  end

  // Pointer moves just past the winner; it stays put when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = gnt_idx + ID_W'(1);
  end

  // ---- stage 0: operand select for the granted requester ----
  always_comb begin
    a_p0    = op_a[int'(gnt_idx)*N +: N];
    b_p0    = op_b[int'(gnt_idx)*N +: N];
    c_p0    = op_c[int'(gnt_idx)*N +: N];
    d_p0    = op_d[int'(gnt_idx)*N +: N];
    x1_p1_d = a_p0 + b_p0;
    x2_p1_d = c_p0 - d_p0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // ---- stage 1: A+B, C-D, D and ID captured on the grant edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      x1_p1_q  <= '0;
      x2_p1_q  <= '0;
      d_p1_q   <= '0;
      id_p1_q  <= '0;
    end else if (!stall) begin
      vld_p1_q <= gnt_any;
      x1_p1_q  <= x1_p1_d;
      x2_p1_q  <= x2_p1_d;
      d_p1_q   <= d_p0;
      id_p1_q  <= gnt_idx;
    end
  end

  // ---- stage 2: x1+x2, carrying the operation's own D and ID ----
  assign x3_p2_d = x1_p1_q + x2_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      x3_p2_q  <= '0;
      d_p2_q   <= '0;
      id_p2_q  <= '0;
    end else if (!stall) begin
      vld_p2_q <= vld_p1_q;
      x3_p2_q  <= x3_p2_d;
      d_p2_q   <= d_p1_q;
      id_p2_q  <= id_p1_q;
    end
  end

  // ---- stage 3: product truncated to N bits into the output register ----
  assign prod_p2 = x3_p2_q * d_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else if (!stall) begin
      res_valid_q <= vld_p2_q;
      res_data_q  <= prod_p2;
      res_id_q    <= id_p2_q;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = vld_p1_q | vld_p2_q | res_valid_q;

`ifdef PIPE_SCHED_STAT_EN
  logic [15:0] stall_cnt_q, issue_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  // Saturating event counters for stalled cycles and issued grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= sat_inc16(stall_cnt_q, stall);
      issue_cnt_q <= sat_inc16(issue_cnt_q, gnt_any);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_sched_arb.sv
// Directed testbench for pipe_sched_arb (N=10, ID_W=2).
module tb_pipe_sched_arb;

  localparam int N    = 10;
  localparam int ID_W = 2;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] op_a = '0, op_b = '0, op_c = '0, op_d = '0;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [N-1:0]      res_data;
  logic [ID_W-1:0]   res_id;
  logic              busy;
`ifdef PIPE_SCHED_STAT_EN
  logic [15:0]       stall_cnt, issue_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_sched_arb #(.N(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_c      (op_c),
    .op_d      (op_d),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
`ifdef PIPE_SCHED_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c, input int d);
    op_a[i*N +: N] = N'(a);
    op_b[i*N +: N] = N'(b);
    op_c[i*N +: N] = N'(c);
    op_d[i*N +: N] = N'(d);
  endtask

  task automatic do_reset();
    req       = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n  = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '1;
    res_ready = 1'b1;
    step();
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    tests_run++;
    if (res_data !== 10'd0) begin tests_failed++; $display("FAIL reset_data: got %0d want 0", res_data); end
    tests_run++;
    if (res_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", res_id); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef PIPE_SCHED_STAT_EN
    tests_run++;
    if (stall_cnt !== 16'd0 || issue_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stall_cnt, issue_cnt);
    end
`endif
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    set_op(0, 3, 4, 10, 2);
    res_ready = 1'b1;
    req = 4'b0001;
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    step();
    req = '0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt); end
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early1: got valid %b want 0", res_valid); end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early2: got valid %b want 0", res_valid); end
    step();
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== 10'd30 || res_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_result: got v=%b d=%0d id=%0d want v=1 d=30 id=0", res_valid, res_data, res_id);
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
    step();
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_drain: got v=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_wrap_arith();
    int va[2]  = '{1000, 0};
    int vb[2]  = '{100, 0};
    int vc[2]  = '{0, 5};
    int vd[2]  = '{1, 7};
    int vid[2] = '{1, 3};
    int vex[2] = '{75, 1010};
    for (int v = 0; v < 2; v++) begin
      set_op(vid[v], va[v], vb[v], vc[v], vd[v]);
      req = '0;
      req[vid[v]] = 1'b1;
      #1;
      tests_run++;
      if (gnt !== req) begin tests_failed++; $display("FAIL wrap_gnt%0d: got %b want %b", v, gnt, req); end
      step();
      req = '0;
      step();
      step();
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== N'(vex[v]) || res_id !== ID_W'(vid[v])) begin
        tests_failed++;
        $display("FAIL wrap_result%0d: got v=%b d=%0d id=%0d want v=1 d=%0d id=%0d",
                 v, res_valid, res_data, res_id, vex[v], vid[v]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, i, 1, 1, 1);
    for (int t = 0; t < 10; t++) begin
      req = (t < 5) ? 4'b1111 : 4'b0000;
      #1;
      exp_gnt = '0;
      if (t < 5) exp_gnt[t % NREQ] = 1'b1;
      tests_run++;
      if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL rr_gnt t=%0d: got %b want %b", t, gnt, exp_gnt); end
      tests_run++;
      if (res_valid !== (t >= 3 && t <= 7)) begin
        tests_failed++; $display("FAIL rr_valid t=%0d: got %b want %b", t, res_valid, (t >= 3 && t <= 7));
      end
      if (t >= 3 && t <= 7) begin
        tests_run++;
        if (res_data !== N'(((t - 3) % 4) + 1) || res_id !== ID_W'((t - 3) % 4)) begin
          tests_failed++;
          $display("FAIL rr_result t=%0d: got d=%0d id=%0d want d=%0d id=%0d",
                   t, res_data, res_id, ((t - 3) % 4) + 1, (t - 3) % 4);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] exp_gnt;
    int exp_d;
    int exp_id;
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 10 * (i + 1), 1, 2, 2);
    set_op(3, 7, 7, 7, 7);
    for (int t = 0; t < 12; t++) begin
      if (t < 3)       req = 4'b0111;
      else if (t < 8)  req = 4'b1000;
      else             req = 4'b0000;
      res_ready = (t >= 8);
      #1;
      exp_gnt = '0;
      if (t < 3) exp_gnt[t] = 1'b1;
      tests_run++;
      if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL bp_gnt t=%0d: got %b want %b", t, gnt, exp_gnt); end
      tests_run++;
      if (res_valid !== (t >= 3 && t <= 10)) begin
        tests_failed++; $display("FAIL bp_valid t=%0d: got %b want %b", t, res_valid, (t >= 3 && t <= 10));
      end
      if (t >= 3 && t <= 10) begin
        exp_id = (t <= 8) ? 0 : t - 8;
        exp_d  = 20 * exp_id + 22;
        tests_run++;
        if (res_data !== N'(exp_d) || res_id !== ID_W'(exp_id)) begin
          tests_failed++;
          $display("FAIL bp_result t=%0d: got d=%0d id=%0d want d=%0d id=%0d", t, res_data, res_id, exp_d, exp_id);
        end
      end
`ifdef PIPE_SCHED_STAT_EN
      if (t == 8) begin
        tests_run++;
        if (stall_cnt !== 16'd5 || issue_cnt !== 16'd3) begin
          tests_failed++; $display("FAIL bp_stats: got stall=%0d issue=%0d want 5/3", stall_cnt, issue_cnt);
        end
      end
`endif
      if (t == 11) begin
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle: got busy %b want 0", busy); end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    int n_valid;
    int n_bad;
    do_reset();
    set_op(0, 3, 4, 10, 2);
    set_op(1, 1, 1, 1, 1);
    set_op(2, 2, 2, 2, 2);
    for (int t = 0; t < 3; t++) begin
      req = '0;
      req[t] = 1'b1;
      step();
    end
    req = '0;
    #1;
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid: got %b want 1", res_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 10'd0 || res_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_async_clear: got v=%b busy=%b d=%0d id=%0d want all 0", res_valid, busy, res_data, res_id);
    end
    step();
    #1 rst_n = 1'b1;
    req = 4'b1111;
    #1;
    tests_run++;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL mid_first_gnt: got %b want 0001", gnt); end
    step();
    req = '0;
    n_valid = 0;
    n_bad   = 0;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (res_valid === 1'b1) begin
        n_valid++;
        if (res_id !== 2'd0 || res_data !== 10'd30) n_bad++;
      end
      step();
    end
    tests_run++;
    if (n_valid != 1 || n_bad != 0) begin
      tests_failed++; $display("FAIL mid_results: got %0d results (%0d wrong) want 1 (0 wrong)", n_valid, n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_wrap_arith();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_sched_arb.md
Name: pipe_sched_arb

Overview:
- Shared-resource scheduler for the team's 3-stage arithmetic pipeline F = ((A+B) + (C-D)) * D.
- Arbitrates NREQ requesters round-robin and issues at most one operation per clock into an embedded 3-stage pipe.
- Carries a valid bit and requester ID alongside the data through every stage.
- Returns each result with its ID over a valid/ready port. Downstream backpressure stalls the whole pipe.

Parameters:
- N, 10, operand and result width in bits.
- ID_W, 2, requester ID width; NREQ = 2**ID_W (4 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high with operands stable until granted.
- op_a  input  NREQ*N  A operands; requester i uses slice [i*N +: N]. Same packing for op_b, op_c, op_d.
- op_b  input  NREQ*N  B operands.
- op_c  input  NREQ*N  C operands.
- op_d  input  NREQ*N  D operands.
- gnt  output  NREQ  one-hot, single-cycle grant pulse; operands are captured on the same edge.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_data  output  N  result F.
- res_id  output  ID_W  index of the requester that issued the result.
- busy  output  1  any stage valid or res_valid high.

Behaviour:
- Reset (async, rst_n low):
  - All stage valid bits cleared; gnt = 0, res_valid = 0, res_data = 0, res_id = 0, busy = 0.
  - Round-robin pointer = 0.
  - Data registers are cleared as well.
- stall = res_valid & ~res_ready. Stall freezes every stage, blocks new grants and holds res_data/res_id.
- gnt is combinational from req, the pointer and stall. The grant is registered into stage 1 on the same edge.
- Grant rule (when not stalled):
  - Search starts at the pointer and wraps modulo NREQ; the first requester with req high is granted.
  - After a grant to requester k, the pointer becomes (k+1) mod NREQ. The pointer is unchanged when there is no grant.
- Stage 1 (S1) registers: x1 = A+B, x2 = C-D, D, id, v1.
- Stage 2 (S2) registers: x3 = x1+x2, D, id, v2. D and id travel with their own operation; the raw input is never re-sampled.
- Stage 3 (S3) is the output register:
  - res_data = x3*D truncated to the low N bits; res_id = id; res_valid = v2.
  - It loads only when not stalled.
- Arithmetic: all operands are unsigned and every result is mod 2**N. The subtraction wraps; only the low N bits of the product are kept.
- Latency: a grant at edge E gives res_valid high after edge E+3 (3 cycles), absent stalls. Throughput is 1 operation per cycle.
- Handshake:
  - A result transfers on a clock edge where res_valid and res_ready are both high. The next result may appear in the same cycle (back-to-back).
  - With res_ready low, res_data/res_id stay stable and res_valid stays high until accepted.
  - Stages advance only when not stalled. No bubble-collapsing is required.
- Boundary cases:
  - No req high: no grant; a bubble (v=0) enters S1.
  - req dropped before grant: that request is never granted. Deasserting req mid-wait is legal.
  - A requester may re-request immediately after its grant pulse. It waits for its next round-robin turn if others are requesting.
  - Reset mid-operation: in-flight results are discarded with no partial output, and the pointer returns to 0.
  - Pointer wrap: after granting NREQ-1, the search restarts at 0.

Optional Feature:
- Macro: PIPE_SCHED_STAT_EN.
- When defined, two extra output ports are present: stall_cnt (16 bits) and issue_cnt (16 bits).
  - stall_cnt counts cycles with stall=1.
  - issue_cnt counts grants.
  - Both saturate at 16'hFFFF and are cleared by rst_n.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single op: req[0]=1, A=3, B=4, C=10, D=2, res_ready=1 -> gnt[0] pulses one cycle; 3 cycles later res_valid=1, res_data=30, res_id=0.
- Wrap arithmetic (N=10): A=1000, B=100, C=0, D=1 -> res_data=75; A=0, B=0, C=5, D=7 -> (1022*7) mod 1024 = 1010.
- Round-robin: all req high from reset, each requester i with A=i, B=C=D=1 -> grants 0,1,2,3,0 in consecutive cycles; results in ID order with res_data 1,2,3,4,1.
- Backpressure: 3 ops in flight, hold res_ready=0 for 5 cycles -> res_valid stays high with first result stable; gnt stays 0; after res_ready=1, remaining results emerge in order with none lost or duplicated.
- Reset mid-flight: pull rst_n low 1 cycle after a grant -> res_valid=0 immediately (async), busy=0; the op never appears; first grant after release goes to requester 0 when all request.
- Stat (PIPE_SCHED_STAT_EN): the backpressure scenario -> stall_cnt=5 and issue_cnt=3.
